// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite command master: FSM encodings,
// response codes and the protection default.
package axi_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // True in the states where an AXI transaction is outstanding.
  function automatic logic is_busy(input state_t s);
    return (s == ST_WR) || (s == ST_WR_RESP) || (s == ST_RD_ADDR) || (s == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// Command/response port plus AXI4-Lite master bus; "master" is the block's
// view, "slave" the view of whatever sits on the other side.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_write;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;
  logic                    rsp_timeout;

  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [2:0]              m_axi_awprot;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [2:0]              m_axi_arprot;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axi_lite_timeout_cnt.sv
// Per-transaction wait counter: clears on command acceptance, counts busy
// cycles, saturates, and flags the cycle whose edge brings it to the limit.
module axi_lite_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Saturating busy-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != '1)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry fires in the last allowed cycle so the abort lands exactly on the limit.
  always_comb begin
    if (TIMEOUT_CYCLES == 0) begin
      expired = 1'b0;
    end else begin
      expired = en && (count_r >= LIMIT);
    end
  end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Turns single read/write commands into AXI4-Lite transactions and returns
// one response per command, with an optional per-transaction timeout.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                   m_axi_aclk,
  input  logic                   m_axi_aresetn,
  axi_lite_cmd_master_if.master  bus
);

  state_t state_r;
  state_t state_nxt_s;
  logic   active_r;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_r;
  logic                            aw_done_r;
  logic                            w_done_r;

  logic                          rsp_write_r;
  logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_r;
  logic [1:0]                    rsp_resp_r;
  logic                          rsp_timeout_r;

  logic cmd_ready_s, awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s, rsp_valid_s;
  logic cmd_hs_s, aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic expired_s, abort_s;

  assign cmd_hs_s = bus.cmd_valid && cmd_ready_s;
  assign aw_hs_s  = awvalid_s && bus.m_axi_awready;
  assign w_hs_s   = wvalid_s && bus.m_axi_wready;
  assign b_hs_s   = bus.m_axi_bvalid && bready_s;
  assign ar_hs_s  = arvalid_s && bus.m_axi_arready;
  assign r_hs_s   = bus.m_axi_rvalid && rready_s;
  assign abort_s  = is_busy(state_r) && expired_s && (state_nxt_s == ST_RSP);

  axi_lite_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (m_axi_aclk),
    .rst_n   (m_axi_aresetn),
    .clr     (cmd_hs_s),
    .en      (is_busy(state_r)),
    .expired (expired_s)
  );

  // State register; active_r keeps cmd_ready low until the first edge out of reset.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_r  <= ST_IDLE;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      active_r <= 1'b1;
    end
  end

  // Next-state logic; a handshake always beats a same-cycle expiry.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_hs_s) begin
          state_nxt_s = bus.cmd_write ? ST_WR : ST_RD_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR: begin
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_nxt_s = ST_WR_RESP;
        end else if (expired_s) begin
          state_nxt_s = ST_RSP;
        end else begin
          state_nxt_s = ST_WR;
        end
      end
      ST_WR_RESP: begin
        if (b_hs_s || expired_s) begin
          state_nxt_s = ST_RSP;
        end else begin
          state_nxt_s = ST_WR_RESP;
        end
      end
      ST_RD_ADDR: begin
        if (ar_hs_s) begin
          state_nxt_s = ST_RD_DATA;
        end else if (expired_s) begin
          state_nxt_s = ST_RSP;
        end else begin
          state_nxt_s = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (r_hs_s || expired_s) begin
          state_nxt_s = ST_RSP;
        end else begin
          state_nxt_s = ST_RD_DATA;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RSP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the state register only; IDLE keeps bready/rready up to drain late beats.
  always_comb begin
    cmd_ready_s = 1'b0;
    awvalid_s   = 1'b0;
    wvalid_s    = 1'b0;
    bready_s    = 1'b0;
    arvalid_s   = 1'b0;
    rready_s    = 1'b0;
    rsp_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = active_r;
        bready_s    = active_r;
        rready_s    = active_r;
      end
      ST_WR: begin
        awvalid_s = !aw_done_r;
        wvalid_s  = !w_done_r;
      end
      ST_WR_RESP: bready_s    = 1'b1;
      ST_RD_ADDR: arvalid_s   = 1'b1;
      ST_RD_DATA: rready_s    = 1'b1;
      ST_RSP:     rsp_valid_s = 1'b1;
      default:    cmd_ready_s = 1'b0;
    endcase
  end

  // Command capture and per-channel write handshake tracking.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      addr_r      <= '0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      rsp_write_r <= 1'b0;
    end else if (cmd_hs_s) begin
      addr_r      <= bus.cmd_addr;
      wdata_r     <= bus.cmd_wdata;
      wstrb_r     <= bus.cmd_wstrb;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      rsp_write_r <= bus.cmd_write;
    end else begin
      aw_done_r <= aw_done_r || aw_hs_s;
      w_done_r  <= w_done_r || w_hs_s;
    end
  end

  // Response capture; B/R beats seen in IDLE are dropped here.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      rsp_rdata_r   <= '0;
      rsp_resp_r    <= RESP_OKAY;
      rsp_timeout_r <= 1'b0;
    end else if ((state_r == ST_WR_RESP) && b_hs_s) begin
      rsp_rdata_r   <= '0;
      rsp_resp_r    <= bus.m_axi_bresp;
      rsp_timeout_r <= 1'b0;
    end else if ((state_r == ST_RD_DATA) && r_hs_s) begin
      rsp_rdata_r   <= bus.m_axi_rdata;
      rsp_resp_r    <= bus.m_axi_rresp;
      rsp_timeout_r <= 1'b0;
    end else if (abort_s) begin
      rsp_rdata_r   <= '0;
      rsp_resp_r    <= RESP_SLVERR;
      rsp_timeout_r <= 1'b1;
    end else begin
      rsp_rdata_r   <= rsp_rdata_r;
      rsp_resp_r    <= rsp_resp_r;
      rsp_timeout_r <= rsp_timeout_r;
    end
  end

  assign bus.cmd_ready     = cmd_ready_s;
  assign bus.rsp_valid     = rsp_valid_s;
  assign bus.rsp_write     = rsp_write_r;
  assign bus.rsp_rdata     = rsp_rdata_r;
  assign bus.rsp_resp      = rsp_resp_r;
  assign bus.rsp_timeout   = rsp_timeout_r;
  assign bus.m_axi_awaddr  = addr_r;
  assign bus.m_axi_awprot  = PROT_DEFAULT;
  assign bus.m_axi_awvalid = awvalid_s;
  assign bus.m_axi_wdata   = wdata_r;
  assign bus.m_axi_wstrb   = wstrb_r;
  assign bus.m_axi_wvalid  = wvalid_s;
  assign bus.m_axi_bready  = bready_s;
  assign bus.m_axi_araddr  = addr_r;
  assign bus.m_axi_arprot  = PROT_DEFAULT;
  assign bus.m_axi_arvalid = arvalid_s;
  assign bus.m_axi_rready  = rready_s;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a configurable AXI4-Lite slave
// model (per-channel ready delays, stalls, programmable response codes).
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi_lite_cmd_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  axi_lite_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(16),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rst_n),
    .bus          (bus)
  );

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  // Slave model knobs (written by the stimulus) and state (written by the model).
  int         aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit         ar_never = 1'b0, b_never = 1'b0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  bit         aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0, b_on = 1'b0, r_on = 1'b0;
  logic [15:0] aw_addr_q = 16'h0, ar_addr_q = 16'h0;
  logic [31:0] w_data_q = 32'h0, r_data_q = 32'h0;
  logic [3:0]  w_strb_q = 4'h0;
  logic [31:0] mem [0:255] = '{default: 32'h0};
  int         b_hs_cnt = 0, rsp_rise_cnt = 0;
  bit         rsp_valid_d = 1'b0;

  // Slave model: sample handshakes mid-cycle, drive outputs just after the edge.
  always begin
    bus.m_axi_awready = (aw_cnt >= aw_delay);
    bus.m_axi_wready  = (w_cnt >= w_delay);
    bus.m_axi_arready = !ar_never && (ar_cnt >= ar_delay);
    bus.m_axi_bvalid  = b_on;
    bus.m_axi_bresp   = bresp_cfg;
    bus.m_axi_rvalid  = r_on;
    bus.m_axi_rdata   = r_data_q;
    bus.m_axi_rresp   = rresp_cfg;
    @(negedge clk);
    if (!rst_n) begin
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      aw_got = 1'b0; w_got = 1'b0; r_pend = 1'b0; b_on = 1'b0; r_on = 1'b0;
    end else begin
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_got = 1'b1; aw_addr_q = bus.m_axi_awaddr; aw_cnt = 0;
      end else if (bus.m_axi_awvalid) aw_cnt++;
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_got = 1'b1; w_data_q = bus.m_axi_wdata; w_strb_q = bus.m_axi_wstrb; w_cnt = 0;
      end else if (bus.m_axi_wvalid) w_cnt++;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        r_pend = 1'b1; ar_addr_q = bus.m_axi_araddr; ar_cnt = 0;
      end else if (bus.m_axi_arvalid) ar_cnt++;
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
        b_on = 1'b0; b_hs_cnt++;
      end
      if (bus.m_axi_rvalid && bus.m_axi_rready) r_on = 1'b0;
      if (aw_got && w_got && !b_on && !b_never) begin
        for (int b = 0; b < 4; b++)
          if (w_strb_q[b]) mem[aw_addr_q[9:2]][8*b +: 8] = w_data_q[8*b +: 8];
        aw_got = 1'b0; w_got = 1'b0; b_on = 1'b1;
      end
      if (r_pend && !r_on) begin
        r_on = 1'b1; r_data_q = mem[ar_addr_q[9:2]]; r_pend = 1'b0;
      end
    end
    if (bus.rsp_valid && !rsp_valid_d) rsp_rise_cnt++;
    rsp_valid_d = bus.rsp_valid;
    @(posedge clk);
    #1;
  end

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a;
    bus.cmd_wdata = d; bus.cmd_wstrb = s;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk); n++;
    end
    if (n >= 40) chk_vec("cmd_accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 60) begin
      @(negedge clk); n++;
    end
    if (n >= 60) chk_vec("rsp_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                        input logic exp_to);
    int n;
    issue(w, a, d, s);
    wait_rsp(n);
    chk_vec({tag, "_write"}, 32'(bus.rsp_write), 32'(w));
    chk_vec({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    chk_vec({tag, "_resp"}, 32'(bus.rsp_resp), 32'(exp_resp));
    chk_vec({tag, "_timeout"}, 32'(bus.rsp_timeout), 32'(exp_to));
    take_rsp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int n, b0, r0, bad;
    logic [31:0] hold_rdata;
    logic [1:0]  hold_resp;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0;
    bus.cmd_wdata = 32'h0; bus.cmd_wstrb = 4'h0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk_vec("rst_outputs", 32'({bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                                bus.m_axi_bready, bus.m_axi_rready, bus.rsp_valid}), 32'd0);
    chk_vec("rst_rsp_fields", 32'({bus.rsp_write, bus.rsp_resp, bus.rsp_timeout}), 32'd0);
    chk_vec("rst_rsp_rdata", bus.rsp_rdata, 32'h0);

    rst_n = 1'b1;
    #1 chk_vec("rel_cmd_ready_pre", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk_vec("rel_cmd_ready_post", 32'(bus.cmd_ready), 32'd1);
    chk_vec("idle_bready_rready", 32'({bus.m_axi_bready, bus.m_axi_rready}), 32'd3);

    // Basic write/read through the slave model
    issue(1'b1, 16'h1004, 32'h5, 4'hF);
    chk_vec("wr_valids_rise", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 32'd3);
    chk_vec("wr_awaddr", 32'(bus.m_axi_awaddr), 32'h1004);
    chk_vec("prot", 32'({bus.m_axi_awprot, bus.m_axi_arprot}), 32'd0);
    wait_rsp(n);
    chk_vec("wr1_write", 32'(bus.rsp_write), 32'd1);
    chk_vec("wr1_resp", 32'(bus.rsp_resp), 32'(RESP_OKAY));
    chk_vec("wr1_rdata", bus.rsp_rdata, 32'h0);
    take_rsp();
    do_cmd("rd1", 1'b0, 16'h1004, 32'h0, 4'h0, 32'h5, RESP_OKAY, 1'b0);

    // Partial strobes: only bytes 0 and 2 are replaced
    do_cmd("wr_strb", 1'b1, 16'h1004, 32'hAABBCCDD, 4'b0101, 32'h0, RESP_OKAY, 1'b0);
    do_cmd("rd_strb", 1'b0, 16'h1004, 32'h0, 4'h0, 32'h00BB00DD, RESP_OKAY, 1'b0);

    // W accepted three cycles before AW
    aw_delay = 3; b0 = b_hs_cnt; r0 = rsp_rise_cnt;
    issue(1'b1, 16'h0040, 32'h11, 4'hF);
    chk_vec("skew_v0", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 32'd3);
    @(negedge clk);
    chk_vec("skew_v1", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 32'd2);
    @(negedge clk);
    chk_vec("skew_v2", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid}), 32'd2);
    wait_rsp(n);
    chk_vec("skew_resp", 32'({bus.rsp_timeout, bus.rsp_resp}), 32'd0);
    take_rsp();
    repeat (2) @(negedge clk);
    chk_vec("skew_b_count", 32'(b_hs_cnt - b0), 32'd1);
    chk_vec("skew_rsp_count", 32'(rsp_rise_cnt - r0), 32'd1);
    aw_delay = 0;

    // Error responses pass through unchanged
    bresp_cfg = RESP_DECERR;
    do_cmd("wr_decerr", 1'b1, 16'h0044, 32'h1, 4'hF, 32'h0, RESP_DECERR, 1'b0);
    bresp_cfg = RESP_OKAY;
    rresp_cfg = RESP_SLVERR;
    do_cmd("rd_slverr", 1'b0, 16'h1004, 32'h0, 4'h0, 32'h00BB00DD, RESP_SLVERR, 1'b0);
    rresp_cfg = RESP_OKAY;

    // Response held for 10 cycles under back-pressure
    do_cmd("wr_dead", 1'b1, 16'h0020, 32'hDEADBEEF, 4'hF, 32'h0, RESP_OKAY, 1'b0);
    issue(1'b0, 16'h0020, 32'h0, 4'h0);
    wait_rsp(n);
    chk_vec("hold_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    hold_rdata = bus.rsp_rdata; hold_resp = bus.rsp_resp; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_rdata !== hold_rdata || bus.rsp_resp !== hold_resp ||
          bus.rsp_timeout || bus.rsp_write || bus.cmd_ready) bad++;
    end
    chk_vec("hold_stable_cycles_bad", 32'(bad), 32'd0);
    take_rsp();
    chk_vec("hold_idle_after", 32'({bus.cmd_ready, bus.rsp_valid}), 32'd2);

    // Timeout: AR never accepted, response 16 cycles after arvalid rises
    ar_never = 1'b1;
    issue(1'b0, 16'h1004, 32'h0, 4'h0);
    wait_rsp(n);
    chk_vec("to_latency", 32'(n), 32'd16);
    chk_vec("to_flag", 32'(bus.rsp_timeout), 32'd1);
    chk_vec("to_resp", 32'(bus.rsp_resp), 32'(RESP_SLVERR));
    chk_vec("to_rdata", bus.rsp_rdata, 32'h0);
    chk_vec("to_arvalid_dropped", 32'(bus.m_axi_arvalid), 32'd0);
    take_rsp();
    ar_never = 1'b0;
    do_cmd("after_to", 1'b1, 16'h0048, 32'h77, 4'hF, 32'h0, RESP_OKAY, 1'b0);

    // AR handshake in the expiry cycle wins; one cycle later it times out
    ar_delay = 15;
    do_cmd("to_edge_hs", 1'b0, 16'h0020, 32'h0, 4'h0, 32'hDEADBEEF, RESP_OKAY, 1'b0);
    ar_delay = 16;
    do_cmd("to_edge_late", 1'b0, 16'h0020, 32'h0, 4'h0, 32'h0, RESP_SLVERR, 1'b1);
    ar_delay = 0;

    // Reset while waiting for B
    b_never = 1'b1; r0 = rsp_rise_cnt;
    issue(1'b1, 16'h004C, 32'h9, 4'hF);
    @(negedge clk);
    chk_vec("wr_resp_bready", 32'(bus.m_axi_bready), 32'd1);
    rst_n = 1'b0;
    #1 chk_vec("midrst_outputs", 32'({bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                                     bus.m_axi_bready, bus.m_axi_rready, bus.rsp_valid}), 32'd0);
    repeat (2) @(negedge clk);
    b_never = 1'b0;
    rst_n = 1'b1;
    #1 chk_vec("midrst_rel_pre", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk_vec("midrst_rel_post", 32'(bus.cmd_ready), 32'd1);
    chk_vec("midrst_no_rsp", 32'(rsp_rise_cnt - r0), 32'd0);
    do_cmd("post_rst_rd", 1'b0, 16'h1004, 32'h0, 4'h0, 32'h00BB00DD, RESP_OKAY, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 16, AXI byte-address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, wait-cycle limit per transaction; 0 disables the timeout.
REQ-004 SHALL use one clock and an asynchronous active-low reset: m_axi_aclk in 1 rising-edge clock; m_axi_aresetn in 1 asynchronous active-low reset.
REQ-005 cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-006 cmd_write in 1: 1 = write, 0 = read.
REQ-007 cmd_addr in ADDR_WIDTH; cmd_wdata in 32; cmd_wstrb in 4: command address, write data, byte strobes.
REQ-008 rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-009 rsp_write out 1: type of completed command; rsp_rdata out 32: read data, 0 for writes.
REQ-010 rsp_resp out 2: AXI BRESP or RRESP; rsp_timeout out 1: transaction aborted by timeout.
REQ-011 SHALL have the full AXI4-Lite master ports with standard directions and widths: m_axi_aw{addr,prot,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,prot,valid,ready}, m_axi_r{data,resp,valid,ready}.

Function
REQ-012 SHALL implement the FSM states IDLE, WR (AW/W outstanding), WR_RESP, RD_ADDR, RD_DATA and RSP.
REQ-013 cmd_ready SHALL be 1 only in IDLE; a command handshake in cycle N SHALL register its fields and assert the AXI valids in cycle N+1.
REQ-014 On a write, awvalid and wvalid SHALL rise together; each SHALL drop independently after its own handshake; the FSM SHALL enter WR_RESP once both handshakes have occurred, including when both occur in the same cycle.
REQ-015 bready SHALL be 1 in WR_RESP; a B handshake SHALL capture bresp and enter RSP.
REQ-016 On a read, arvalid SHALL be held until arready; the FSM SHALL then enter RD_DATA with rready=1; an R handshake SHALL capture rdata/rresp and enter RSP.
REQ-017 While any valid is asserted, the block SHALL hold every address/data/strb/valid signal stable until its handshake.
REQ-018 awprot and arprot SHALL be 3'b000.
REQ-019 In RSP, rsp_valid SHALL be 1 with stable fields until rsp_ready; the FSM SHALL then return to IDLE, giving a back-to-back command throughput of no better than one command per 4 cycles.
REQ-020 The timeout counter SHALL clear on command acceptance, increment in every WR/WR_RESP/RD_ADDR/RD_DATA cycle, and saturate.
REQ-021 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL drop all AXI valids, enter RSP with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
REQ-022 A handshake in the same cycle as the timeout expiry SHALL win, completing normally with rsp_timeout=0.
REQ-023 In IDLE, bready and rready SHALL be 1 so that late B/R beats after a timeout are consumed and discarded.
REQ-024 A non-OKAY bresp/rresp SHALL be passed through unchanged; the block SHALL perform no retry.

Reset
REQ-025 While m_axi_aresetn=0, the FSM SHALL be IDLE, all AXI valids 0, bready/rready 0, cmd_ready 0, rsp_valid 0, rsp_* fields 0 and the counter 0.
REQ-026 Reset assertion mid-transaction SHALL abort immediately with no response generated.
REQ-027 cmd_ready SHALL first be 1 in the cycle after the first rising clock edge with reset released.

Structure
REQ-028 A shared package/include axi_lite_pkg SHALL hold the FSM state encodings, the RESP codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) and the PROT default.
REQ-029 One sub-module axi_lite_timeout_cnt SHALL hold the clear/enable/saturate counter and its expiry flag; the rest SHALL be flat.

Verification
REQ-030 Bench SHALL drive a write with cmd_addr=16'h1004, cmd_wdata=32'h5, cmd_wstrb=4'hF into axi_lite_slave_example, then a read of 16'h1004 -> write response resp=00; read response rdata=32'h5, resp=00.
REQ-031 Bench SHALL use a BFM slave with wready 3 cycles before awready -> wvalid drops after the W handshake, awvalid is held, exactly one B handshake occurs, rsp_valid is asserted once.
REQ-032 Bench SHALL use a BFM slave that never asserts arready, with TIMEOUT_CYCLES=16 -> rsp_valid with rsp_timeout=1, resp=10 at 16 cycles after the valids rise; the following command is accepted.
REQ-033 Bench SHALL hold rsp_ready=0 for 10 cycles after a read of 32'hDEADBEEF -> rsp fields stay stable, cmd_ready stays 0, the FSM returns to IDLE one cycle after rsp_ready=1.
REQ-034 Bench SHALL assert m_axi_aresetn=0 while in WR_RESP -> all valids 0 asynchronously, no rsp_valid; cmd_ready=1 in the cycle after the first clock edge following release.
REQ-035 Bench SHALL make a BFM slave return rresp=2'b10 -> rsp_resp=10, rsp_timeout=0.
